alu_seq: RTL and testbench

Command sequencer that sits directly upstream of the 8-bit combinational ALU (modes 00 SRA, 01 SHL, 10 ADD, 11 SUB). It owns a 4-entry × 8-bit register file, accepts one command at a time over a valid/ready handshake, and drives the ALU operand and mode inputs. It captures the ALU result into the register file and onto a one-cycle result strobe. It also provides an 8-bit multiply, built as a multi-cycle shift-and-add loop that uses only the ALU's ADD and SHL modes.

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Command sequencer in front of an 8-bit combinational ALU: 4x8 register file,
// valid/ready command intake, and a shift-and-add multiply built from ADD/SHL.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_srcA,
    input  logic [1:0] cmd_srcB,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    output logic [1:0] alu_mode,
    input  logic [7:0] alu_Y,
    output logic [7:0] res,
    output logic       res_vld
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MUL_ADD = 2'd2,
        MUL_SHL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_SRA  = 3'b000,
        OP_SHL  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LDI  = 3'b100,
        OP_MUL  = 3'b101,
        OP_NOP0 = 3'b110,
        OP_NOP1 = 3'b111
    } op_t;

    localparam logic [1:0] MODE_SHL = 2'b01;
    localparam logic [1:0] MODE_ADD = 2'b10;

    state_t     state;
    op_t        op;
    logic [1:0] dst;
    logic [7:0] imm;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] acc;
    logic [7:0] mcand;
    logic [7:0] mplier;
    logic [2:0] cnt;
    logic [7:0] rf [4];

    assign cmd_rdy = (state == IDLE);

    // ALU drive is a pure function of registered state, so it is glitch-free per cycle.
    always_comb begin
        alu_A    = '0;
        alu_B    = '0;
        alu_mode = 2'b00;
        case (state)
            EXEC: begin
                if (op inside {OP_SRA, OP_SHL, OP_ADD, OP_SUB}) begin
                    alu_mode = 2'(op);
                    alu_A    = op_a;
                    alu_B    = op_b;
                end
            end
            MUL_ADD: begin
                alu_mode = MODE_ADD;
                alu_A    = acc;
                alu_B    = mcand;
            end
            MUL_SHL: begin
                alu_mode = MODE_SHL;
                alu_A    = acc;
                alu_B    = mcand;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op      <= OP_NOP0;
            dst     <= '0;
            imm     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else begin
            res_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_vld) begin
                        op   <= op_t'(cmd_op);
                        dst  <= cmd_dst;
                        imm  <= cmd_imm;
                        op_a <= rf[cmd_srcA];
                        op_b <= rf[cmd_srcB];
                        if (op_t'(cmd_op) == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= rf[cmd_srcA];
                            mplier <= rf[cmd_srcB];
                            cnt    <= '0;
                            state  <= MUL_ADD;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    case (op)
                        OP_SRA, OP_SHL, OP_ADD, OP_SUB: begin
                            rf[dst] <= alu_Y;
                            res     <= alu_Y;
                        end
                        OP_LDI: begin
                            rf[dst] <= imm;
                            res     <= imm;
                        end
                        default: res <= '0;
                    endcase
                    res_vld <= 1'b1;
                    state   <= IDLE;
                end
                MUL_ADD: begin
                    if (mplier[0]) begin
                        acc <= alu_Y;
                    end
                    state <= MUL_SHL;
                end
                MUL_SHL: begin
                    mcand  <= alu_Y;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rf[dst] <= acc;
                        res     <= acc;
                        res_vld <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= MUL_ADD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural model of the downstream ALU.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srcA;
    logic [1:0] cmd_srcB;
    logic [7:0] cmd_imm;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [1:0] alu_mode;
    logic [7:0] alu_Y;
    logic [7:0] res;
    logic       res_vld;

    alu_seq dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_op   (cmd_op),
        .cmd_dst  (cmd_dst),
        .cmd_srcA (cmd_srcA),
        .cmd_srcB (cmd_srcB),
        .cmd_imm  (cmd_imm),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_mode (alu_mode),
        .alu_Y    (alu_Y),
        .res      (res),
        .res_vld  (res_vld)
    );

    always #5 clk = ~clk;

    // Downstream ALU: SRA and SHL act on B by one bit, ADD/SUB are A op B.
    always_comb begin
        case (alu_mode)
            2'b00:   alu_Y = {alu_B[7], alu_B[7:1]};
            2'b01:   alu_Y = {alu_B[6:0], 1'b0};
            2'b10:   alu_Y = alu_A + alu_B;
            default: alu_Y = alu_A - alu_B;
        endcase
    end

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ready_due = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && res_vld) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_res_vld: got res=%02h at cycle %0d, required no strobe", res, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (res !== e.data) begin
                    fails++;
                    $display("FAIL res_value: got %02h, required %02h", res, e.data);
                end
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL res_latency: strobe at cycle %0d, required %0d", cyc, e.due);
                end
            end
        end
    end

    localparam logic [2:0] SRA = 3'b000, SHL = 3'b001, ADD = 3'b010, SUB = 3'b011,
                           LDI = 3'b100, MUL = 3'b101, NOP = 3'b110, NOP2 = 3'b111;

    // Called and returning at a falling edge; leaves cmd_vld asserted so the
    // next call presents its command while the DUT is still busy.
    task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                        input logic [1:0] b, input logic [7:0] imm, input logic [7:0] exp_res,
                        input bit push);
        int start;
        int lat;
        int n;
        exp_t e;
        lat = (op == MUL) ? 17 : 2;
        start = cyc;
        cmd_op = op; cmd_dst = dst; cmd_srcA = a; cmd_srcB = b; cmd_imm = imm;
        cmd_vld = 1'b1;
        n = 0;
        while (!cmd_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: cmd_rdy=%0b after %0d cycles, required 1", cmd_rdy, n);
            return;
        end
        if (start < ready_due) begin
            tests++;
            if (cyc != ready_due) begin
                fails++;
                $display("FAIL busy_hold: accepted at cycle %0d, required %0d", cyc, ready_due);
            end
        end
        if (push) begin
            e.data = exp_res;
            e.due  = cyc + lat;
            sb.push_back(e);
        end
        ready_due = cyc + lat;
        @(negedge clk);
        tests++;
        if (cmd_rdy !== 1'b0) begin
            fails++;
            $display("FAIL rdy_cycle1: cmd_rdy=%0b, required 0", cmd_rdy);
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %02h, required %02h", name, got, want);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_vld = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srcA = '0; cmd_srcB = '0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        check("reset_res", res, 8'h00);
        check("reset_res_vld", {7'd0, res_vld}, 8'h00);
        check("reset_cmd_rdy", {7'd0, cmd_rdy}, 8'h01);
        check("reset_alu_A", alu_A, 8'h00);
        check("reset_alu_mode", {6'd0, alu_mode}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        send(LDI, 2'd0, 2'd0, 2'd0, 8'hAA, 8'hAA, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h56, 8'h56, 1);
        send(SRA, 2'd2, 2'd0, 2'd1, 8'h00, 8'h2B, 1);
        send(LDI, 2'd3, 2'd0, 2'd0, 8'hAB, 8'hAB, 1);
        send(SRA, 2'd2, 2'd0, 2'd3, 8'h00, 8'hD5, 1);
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h6E, 8'h6E, 1);
        send(SHL, 2'd3, 2'd1, 2'd0, 8'h00, 8'hDC, 1);
        send(LDI, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h95, 8'h95, 1);
        send(ADD, 2'd2, 2'd1, 2'd0, 8'h00, 8'h03, 1);
        send(ADD, 2'd2, 2'd2, 2'd3, 8'h00, 8'h03, 1);
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h4A, 8'h4A, 1);
        send(ADD, 2'd2, 2'd1, 2'd0, 8'h00, 8'hDF, 1);
        send(ADD, 2'd2, 2'd2, 2'd3, 8'h00, 8'hDF, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h9C, 8'h9C, 1);
        send(SUB, 2'd2, 2'd1, 2'd0, 8'h00, 8'h52, 1);
        send(ADD, 2'd1, 2'd2, 2'd3, 8'h00, 8'h52, 1);
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h56, 8'h56, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h7D, 8'h7D, 1);
        send(SUB, 2'd2, 2'd0, 2'd1, 8'h00, 8'hD9, 1);
        send(ADD, 2'd0, 2'd2, 2'd3, 8'h00, 8'hD9, 1);

        send(LDI, 2'd0, 2'd0, 2'd0, 8'h0D, 8'h0D, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h0B, 8'h0B, 1);
        send(MUL, 2'd2, 2'd0, 2'd1, 8'h00, 8'h8F, 1);
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h95, 8'h95, 1);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h4A, 8'h4A, 1);
        send(MUL, 2'd2, 2'd0, 2'd1, 8'h00, 8'h12, 1);
        send(ADD, 2'd1, 2'd2, 2'd3, 8'h00, 8'h12, 1);

        send(LDI, 2'd0, 2'd0, 2'd0, 8'h10, 8'h10, 1);
        send(ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h20, 1);
        send(ADD, 2'd1, 2'd0, 2'd3, 8'h00, 8'h20, 1);
        send(NOP, 2'd0, 2'd1, 2'd1, 8'h5A, 8'h00, 1);
        send(NOP2, 2'd1, 2'd0, 2'd0, 8'hFF, 8'h00, 1);
        send(ADD, 2'd2, 2'd0, 2'd3, 8'h00, 8'h20, 1);
        send(ADD, 2'd2, 2'd1, 2'd3, 8'h00, 8'h20, 1);

        send(LDI, 2'd1, 2'd0, 2'd0, 8'h77, 8'h77, 1);
        send(MUL, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00, 0);
        cmd_vld = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_res", res, 8'h00);
        check("abort_res_vld", {7'd0, res_vld}, 8'h00);
        check("abort_cmd_rdy", {7'd0, cmd_rdy}, 8'h01);
        check("abort_alu_B", alu_B, 8'h00);
        check("abort_alu_mode", {6'd0, alu_mode}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        ready_due = 0;
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h01, 8'h01, 1);
        send(ADD, 2'd2, 2'd1, 2'd3, 8'h00, 8'h00, 1);
        send(ADD, 2'd3, 2'd0, 2'd1, 8'h00, 8'h01, 1);
        cmd_vld = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
